// File: rtl/ushift_rr_sched.sv
`default_nettype none
// ============================================================================
// Module     : ushift_rr_sched
// Description: Sequencer and two-requester arbiter for a 4-bit universal
//              shift register. Picks one client per rotate job and drives the
//              register through load, N rotate-right cycles and hold. Then it
//              returns the rotated word to the owning client with a one-cycle
//              done pulse.
//
// Configuration macro:
//   USHIFT_RR_SCHED_RR_EN  defined   -> round-robin tie break (the client
//                                       other than the last owner wins)
//                          undefined -> fixed priority (req0 wins a tie)
//
// Parameters:
//   CNT_W        width of each rotate-amount field (amounts 0..2^CNT_W-1)
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   req0/req1    job requests, held until gnt is seen
//   data0/data1  4-bit job data, sampled with the request
//   amt0/amt1    rotate-right count, sampled with the request
//   gnt          one-hot registered grant pulse
//   sel          shift register mode: 00 hold, 01 load, 10 rotate right
//   i_par        parallel-load word to the shift register
//   a_par        shift register contents
//   busy         high whenever the sequencer is not idle
//   done         one-cycle pulse, result/owner valid while high
//   result       rotated word, held until the next done
//   owner        requester index that owns result
//
// Revision   : 1.0  initial release
// ============================================================================
module ushift_rr_sched #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [3:0]       data0,
    input  logic [3:0]       data1,
    input  logic [CNT_W-1:0] amt0,
    input  logic [CNT_W-1:0] amt1,
    output logic [1:0]       gnt,
    output logic [1:0]       sel,
    output logic [3:0]       i_par,
    input  logic [3:0]       a_par,
    output logic             busy,
    output logic             done,
    output logic [3:0]       result,
    output logic             owner
);

    // ------------------------------------------------------------------------
    // State and shift-register mode encodings
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_LOAD  = 2'd1;
    localparam logic [1:0] c_S_SHIFT = 2'd2;
    localparam logic [1:0] c_S_DONE  = 2'd3;

    localparam logic [1:0] c_SEL_HOLD = 2'b00;
    localparam logic [1:0] c_SEL_LOAD = 2'b01;
    localparam logic [1:0] c_SEL_ROTR = 2'b10;

    localparam logic [CNT_W-1:0] c_CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [3:0]       r_i_par;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_gnt;
    logic             r_busy;
    logic             r_done;
    logic [3:0]       r_result;
    logic             r_owner;
    logic             r_winner;   // requester owning the job in flight

    // ------------------------------------------------------------------------
    // Arbitration: w_pick1 is high when requester 1 wins this IDLE sample.
    // Only meaningful while at least one request is high.
    // ------------------------------------------------------------------------
    logic w_any_req;
    logic w_pick1;

    assign w_any_req = req0 | req1;

`ifdef USHIFT_RR_SCHED_RR_EN
    logic r_last_owner;

    // On a tie the requester that did not own the previous job wins.
    // last_owner resets to 1 so requester 0 takes the first tie.
    assign w_pick1 = req1 & (~req0 | ~r_last_owner);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_owner <= 1'b1;
        end else if (r_state == c_S_DONE) begin
            r_last_owner <= r_winner;
        end
    end
`else
    // Fixed priority: requester 0 always wins a tie.
    assign w_pick1 = req1 & ~req0;
`endif

    // ------------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_S_IDLE;
            r_i_par  <= 4'b0000;
            r_cnt    <= c_CNT_ZERO;
            r_gnt    <= 2'b00;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= 4'b0000;
            r_owner  <= 1'b0;
            r_winner <= 1'b0;
        end else begin
            // Grant and done are single-cycle pulses.
            r_gnt  <= 2'b00;
            r_done <= 1'b0;

            case (r_state)
                c_S_IDLE: begin
                    if (w_any_req) begin
                        r_winner <= w_pick1;
                        r_i_par  <= w_pick1 ? data1 : data0;
                        r_cnt    <= w_pick1 ? amt1  : amt0;
                        r_gnt    <= w_pick1 ? 2'b10 : 2'b01;
                        r_busy   <= 1'b1;
                        r_state  <= c_S_LOAD;
                    end
                end

                c_S_LOAD: begin
                    // A zero amount skips the rotate phase entirely.
                    r_state <= (r_cnt != c_CNT_ZERO) ? c_S_SHIFT : c_S_DONE;
                end

                c_S_SHIFT: begin
                    r_cnt <= r_cnt - c_CNT_ONE;
                    // Leaving when cnt==1 yields exactly amt rotate cycles.
                    if (r_cnt == c_CNT_ONE) begin
                        r_state <= c_S_DONE;
                    end
                end

                c_S_DONE: begin
                    // The register has completed its last rotate at the end
                    // of the previous cycle, so a_par is final here.
                    r_result <= a_par;
                    r_owner  <= r_winner;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= c_S_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Shift register mode decode (from registered state only)
    // ------------------------------------------------------------------------
    logic [1:0] w_sel;

    always_comb begin
        w_sel = c_SEL_HOLD;
        case (r_state)
            c_S_LOAD:  w_sel = c_SEL_LOAD;
            c_S_SHIFT: w_sel = c_SEL_ROTR;
            default:   w_sel = c_SEL_HOLD;
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign gnt    = r_gnt;
    assign sel    = w_sel;
    assign i_par  = r_i_par;
    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign owner  = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_ushift_rr_sched.sv
`default_nettype none
// ============================================================================
// Module     : tb_ushift_rr_sched
// Description: Self-checking bench for ushift_rr_sched. A behavioural 4-bit
//              universal shift register closes the loop; directed jobs push
//              expected grant/owner/result/latency entries into a queue that
//              a separate monitor consumes.
// Revision   : 1.0  initial release
// ============================================================================
module tb_ushift_rr_sched;

    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0, req1;
    logic [3:0]       data0, data1;
    logic [CNT_W-1:0] amt0, amt1;
    logic [1:0]       gnt, sel;
    logic [3:0]       i_par, a_par;
    logic             busy, done;
    logic [3:0]       result;
    logic             owner;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ushift_rr_sched #(.CNT_W(CNT_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .req0   (req0),
        .req1   (req1),
        .data0  (data0),
        .data1  (data1),
        .amt0   (amt0),
        .amt1   (amt1),
        .gnt    (gnt),
        .sel    (sel),
        .i_par  (i_par),
        .a_par  (a_par),
        .busy   (busy),
        .done   (done),
        .result (result),
        .owner  (owner)
    );

    // Behavioural universal shift register (clear_b tied inactive).
    logic [3:0] sr = 4'h0;
    always @(posedge clk) begin
        case (sel)
            2'b01:   sr <= i_par;
            2'b10:   sr <= {sr[0], sr[3:1]};
            default: sr <= sr;
        endcase
    end
    assign a_par = sr;

    // ------------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic [1:0] g;
        logic       o;
        logic [3:0] r;
        logic [7:0] amt;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    logic inflight = 1'b0;
    int   cyc = 0;
    int   gcyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic push(input logic [1:0] g, input logic o, input logic [3:0] r, input int a);
        exp_t e;
        e.g = g; e.o = o; e.r = r; e.amt = 8'(a);
        exp_q.push_back(e);
    endtask

    // Monitor: grants open a job, done closes it.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (sel === 2'b11) chk("sel_never_11", 32'(sel), 32'h0);
            if (rst === 1'b1) begin
                inflight = 1'b0;   // aborted job produces no done
            end else begin
                if (done === 1'b1) begin
                    if (!inflight) begin
                        chk("done_without_job", 32'(done), 32'h0);
                    end else begin
                        chk("result", 32'(result), 32'(cur.r));
                        chk("owner", 32'(owner), 32'(cur.o));
                        chk("latency", 32'(cyc - gcyc), 32'(cur.amt) + 32'd2);
                        inflight = 1'b0;
                    end
                end
                if (gnt !== 2'b00) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_gnt", 32'(gnt), 32'h0);
                    end else begin
                        cur = exp_q.pop_front();
                        chk("gnt", 32'(gnt), 32'(cur.g));
                        inflight = 1'b1;
                        gcyc = cyc;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnts(input int n);
        int seen = 0;
        int t = 0;
        while (seen < n && t < 200) begin
            @(negedge clk);
            if (gnt !== 2'b00) seen++;
            t++;
        end
        if (seen < n) chk("gnt_timeout", 32'(seen), 32'(n));
    endtask

    task automatic settle();
        int t = 0;
        @(negedge clk);
        while ((inflight || busy !== 1'b0) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("settle_timeout", 32'(t), 32'h0);
        next_cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Directed tests
    // ------------------------------------------------------------------------
    initial begin
        rst = 1'b1;
        req0 = 1'b1; req1 = 1'b1;
        data0 = 4'b1011; amt0 = 2'd1;
        data1 = 4'b1000; amt1 = 2'd3;

        // Test 1: reset held two cycles with both requests high.
        next_cycle();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_sel", 32'(sel), 32'h0);
            chk("rst_gnt", 32'(gnt), 32'h0);
            chk("rst_busy", 32'(busy), 32'h0);
            chk("rst_done", 32'(done), 32'h0);
            chk("rst_result", 32'(result), 32'h0);
            next_cycle();
        end
        push(2'b01, 1'b0, 4'b1101, 1);
        rst = 1'b0;
        @(negedge clk);
        chk("t1_gnt_first_idle", 32'(gnt), 32'h0);
        next_cycle();
        @(negedge clk);
        chk("t1_gnt_after_rst", 32'(gnt), 32'h1);
        next_cycle();
        req0 = 1'b0; req1 = 1'b0;
        settle();

        // Test 2: single job, data 1011 rotated right by 1.
        req0 = 1'b1; data0 = 4'b1011; amt0 = 2'd1;
        push(2'b01, 1'b0, 4'b1101, 1);
        @(negedge clk);
        chk("t2_sel_c0", 32'(sel), 32'h0);
        next_cycle();
        @(negedge clk);
        chk("t2_sel_c1", 32'(sel), 32'h1);
        chk("t2_busy_c1", 32'(busy), 32'h1);
        next_cycle();
        req0 = 1'b0;
        @(negedge clk);
        chk("t2_sel_c2", 32'(sel), 32'h2);
        next_cycle();
        @(negedge clk);
        chk("t2_sel_c3", 32'(sel), 32'h0);
        next_cycle();
        @(negedge clk);
        chk("t2_done_c4", 32'(done), 32'h1);
        chk("t2_busy_c4", 32'(busy), 32'h0);
        settle();

        // Test 3: zero amount from requester 1.
        req1 = 1'b1; data1 = 4'b0110; amt1 = 2'd0;
        push(2'b10, 1'b1, 4'b0110, 0);
        wait_gnts(1);
        next_cycle();
        req1 = 1'b0;
        @(negedge clk);
        chk("t3_sel_c2_done", 32'(sel), 32'h0);
        settle();

        // Test 4: tie with both requests held for three jobs.
        do_reset();
        data0 = 4'b0001; amt0 = 2'd2;
        data1 = 4'b1000; amt1 = 2'd3;
`ifdef USHIFT_RR_SCHED_RR_EN
        push(2'b01, 1'b0, 4'b0100, 2);
        push(2'b10, 1'b1, 4'b0001, 3);
        push(2'b01, 1'b0, 4'b0100, 2);
`else
        push(2'b01, 1'b0, 4'b0100, 2);
        push(2'b01, 1'b0, 4'b0100, 2);
        push(2'b01, 1'b0, 4'b0100, 2);
`endif
        req0 = 1'b1; req1 = 1'b1;
        wait_gnts(3);
        next_cycle();
        req0 = 1'b0; req1 = 1'b0;
        settle();

        // Test 5: reset during the second SHIFT cycle of an amt=3 job.
        req0 = 1'b1; data0 = 4'b1001; amt0 = 2'd3;
        push(2'b01, 1'b0, 4'b0011, 3);
        next_cycle();                       // cycle 1: LOAD
        next_cycle();                       // cycle 2: first SHIFT
        req0 = 1'b0;
        req1 = 1'b1; data1 = 4'b0110; amt1 = 2'd0;
        push(2'b10, 1'b1, 4'b0110, 0);
        next_cycle();                       // cycle 3: second SHIFT
        rst = 1'b1;
        @(negedge clk);
        chk("t5_sel_shift2", 32'(sel), 32'h2);
        next_cycle();                       // cycle 4: IDLE after reset
        rst = 1'b0;
        @(negedge clk);
        chk("t5_sel_idle", 32'(sel), 32'h0);
        chk("t5_busy_idle", 32'(busy), 32'h0);
        chk("t5_done_idle", 32'(done), 32'h0);
        next_cycle();
        @(negedge clk);
        chk("t5_pending_gnt", 32'(gnt), 32'h2);
        next_cycle();
        req1 = 1'b0;
        settle();

        // Test 6: request held through done re-grants with the same data.
        req0 = 1'b1; data0 = 4'b0011; amt0 = 2'd2;
        push(2'b01, 1'b0, 4'b1100, 2);
        push(2'b01, 1'b0, 4'b1100, 2);
        begin
            int t = 0;
            @(negedge clk);
            while (done !== 1'b1 && t < 50) begin
                @(negedge clk);
                t++;
            end
            chk("t6_done_seen", 32'(done), 32'h1);
        end
        @(negedge clk);
        chk("t6_regrant", 32'(gnt), 32'h1);
        next_cycle();
        req0 = 1'b0;
        settle();

        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        chk("no_job_inflight", 32'(inflight), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
